// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core load/store
// port and a DMA/debug port with bursts. The core has priority, DMA gets an
// anti-starvation slot, and a DMA burst keeps the memory locked until its last beat
// or until MAX_BURST beats have gone through.
// Optional grant/conflict statistics are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic              c_req_we,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DATA_W-1:0] c_req_wdata,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rsp_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic              d_req_last,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,
  output logic              mem_store_instruction,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_core_grants,
  output logic [15:0]       stat_dma_grants,
  output logic [15:0]       stat_conflicts
`endif
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ST_ARB, ST_DMA_LOCK} state_t;

  state_t            r_state, w_state_n;
  logic [SC_W-1:0]   r_starve_cnt, w_starve_cnt_n;
  logic [BC_W-1:0]   r_beat_cnt, w_beat_cnt_n;
  logic [BC_W-1:0]   w_beat_inc;
  logic              r_core_first, w_core_first_n;
  logic              w_grant_c, w_grant_d;
  logic              r_c_rsp_valid, r_d_rsp_valid;
  logic [DATA_W-1:0] r_c_rsp_rdata, r_d_rsp_rdata;

  assign w_beat_inc = r_beat_cnt + BC_W'(1);

  // State, counter and flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_ARB;
      r_starve_cnt <= '0;
      r_beat_cnt   <= '0;
      r_core_first <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_starve_cnt <= w_starve_cnt_n;
      r_beat_cnt   <= w_beat_cnt_n;
      r_core_first <= w_core_first_n;
    end
  end

  // Grant selection, next state and counter updates
  always_comb begin
    w_state_n      = r_state;
    w_starve_cnt_n = r_starve_cnt;
    w_beat_cnt_n   = r_beat_cnt;
    w_core_first_n = r_core_first;
    w_grant_c      = 1'b0;
    w_grant_d      = 1'b0;
    case (r_state)
      ST_ARB: begin
        w_core_first_n = 1'b0;
        if (c_req_valid &&
            (r_core_first || !(d_req_valid && r_starve_cnt == SC_W'(STARVE_LIMIT)))) begin
          w_grant_c = 1'b1;
        end else if (d_req_valid) begin
          w_grant_d = 1'b1;
        end
        if (w_grant_d) begin
          w_starve_cnt_n = '0;
          if (!d_req_last) begin
            w_state_n    = ST_DMA_LOCK;
            w_beat_cnt_n = BC_W'(1);
          end
        end else if (d_req_valid && r_starve_cnt != SC_W'(STARVE_LIMIT)) begin
          w_starve_cnt_n = r_starve_cnt + SC_W'(1);
        end
      end
      ST_DMA_LOCK: begin
        w_grant_d = d_req_valid;
        if (w_grant_d) begin
          w_starve_cnt_n = '0;
          w_beat_cnt_n   = w_beat_inc;
          if (d_req_last || w_beat_inc == BC_W'(MAX_BURST)) begin
            w_state_n    = ST_ARB;
            w_beat_cnt_n = '0;
          end
          // A forced release hands the next ARB cycle to a waiting core
          if (w_beat_inc == BC_W'(MAX_BURST)) begin
            w_core_first_n = c_req_valid;
          end
        end
      end
      default: w_state_n = ST_ARB;
    endcase
  end

  assign c_req_ready = w_grant_c;
  assign d_req_ready = w_grant_d;
  assign busy        = (r_state == ST_DMA_LOCK);

  // Memory port mux; all zero when nobody is granted
  always_comb begin
    mem_store_instruction = 1'b0;
    mem_address           = '0;
    mem_data_in           = '0;
    if (w_grant_c) begin
      mem_store_instruction = c_req_we;
      mem_address           = c_req_addr;
      mem_data_in           = c_req_wdata;
    end else if (w_grant_d) begin
      mem_store_instruction = d_req_we;
      mem_address           = d_req_addr;
      mem_data_in           = d_req_wdata;
    end
  end

  // Load responses: one-cycle valid pulse, data held until the next load response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c_rsp_valid <= 1'b0;
      r_d_rsp_valid <= 1'b0;
      r_c_rsp_rdata <= '0;
      r_d_rsp_rdata <= '0;
    end else begin
      r_c_rsp_valid <= w_grant_c && !c_req_we;
      r_d_rsp_valid <= w_grant_d && !d_req_we;
      if (w_grant_c && !c_req_we) r_c_rsp_rdata <= mem_data_out;
      if (w_grant_d && !d_req_we) r_d_rsp_rdata <= mem_data_out;
    end
  end

  assign c_rsp_valid = r_c_rsp_valid;
  assign c_rsp_rdata = r_c_rsp_rdata;
  assign d_rsp_valid = r_d_rsp_valid;
  assign d_rsp_rdata = r_d_rsp_rdata;

`ifdef DMEM_ARB_STATS_EN
  // Saturating grant and conflict counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_core_grants <= '0;
      stat_dma_grants  <= '0;
      stat_conflicts   <= '0;
    end else begin
      if (w_grant_c && stat_core_grants != 16'hFFFF) stat_core_grants <= stat_core_grants + 16'd1;
      if (w_grant_d && stat_dma_grants != 16'hFFFF)  stat_dma_grants  <= stat_dma_grants + 16'd1;
      if (c_req_valid && d_req_valid && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates one single-port data memory between two requesters: the core load/store port and a DMA/debug port that supports bursts.
- Core has priority, with an anti-starvation guarantee for DMA. DMA bursts hold the grant until the last beat.
- Drives the memory's write-enable, address and write-data inputs. Registers read data into per-requester responses.

Parameters:
- ADDR_W, 32, request/memory address width
- DATA_W, 32, data width
- MAX_BURST, 8, maximum DMA beats per lock before a forced release
- STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA beats core

Ports:
- clk  in  1  clock; all state changes on posedge
- reset_n  in  1  asynchronous active-low reset
- c_req_valid  in  1  core request valid
- c_req_ready  out  1  core request accepted this cycle
- c_req_we  in  1  core store (1) / load (0)
- c_req_addr  in  ADDR_W  core address
- c_req_wdata  in  DATA_W  core store data
- c_rsp_valid  out  1  core load data valid
- c_rsp_rdata  out  DATA_W  core load data
- d_req_valid  in  1  DMA request valid
- d_req_ready  out  1  DMA request accepted this cycle
- d_req_we  in  1  DMA store/load
- d_req_addr  in  ADDR_W  DMA address
- d_req_wdata  in  DATA_W  DMA store data
- d_req_last  in  1  final beat of DMA burst
- d_rsp_valid  out  1  DMA load data valid
- d_rsp_rdata  out  DATA_W  DMA load data
- mem_store_instruction  out  1  memory write enable
- mem_address  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_data_out  in  DATA_W  memory combinational read data
- busy  out  1  high while in DMA_LOCK

Behaviour:
- Handshake: a beat is accepted when valid&&ready at posedge. The requester holds request fields stable while valid&&!ready.
- ready is combinational from state, counters and valids. ready never depends on ready.
- Memory signals are combinational from the granted requester in the acceptance cycle.
- mem_store_instruction = accepted && we. The memory writes at that same posedge.
- With no grant, all mem outputs are 0.
- Loads: rsp_valid pulses exactly one cycle, N+1, for a load accepted in cycle N. rsp_rdata = mem_data_out sampled at the N posedge and held until the next load response.
- Stores produce no response.
- States:
  - ARB (reset state)
  - DMA_LOCK
- ARB grant order:
  1. DMA, if d_req_valid && starve_cnt==STARVE_LIMIT.
  2. Otherwise core, if c_req_valid.
  3. Otherwise DMA, if d_req_valid.
- starve_cnt (in ARB): increments, saturating at STARVE_LIMIT, each cycle d_req_valid is high and DMA is not granted. Clears to 0 on any DMA grant.
- ARB -> DMA_LOCK: on an accepted DMA beat with d_req_last=0. beat_cnt is set to 1.
- DMA_LOCK:
  - Only DMA can be granted; c_req_ready=0.
  - Idle DMA cycles keep the lock.
  - Each accepted beat increments beat_cnt.
  - Returns to ARB on an accepted beat with d_req_last=1, or on the accepted beat that brings beat_cnt to MAX_BURST (forced release).
- After a forced release with c_req_valid high, the core wins the next ARB cycle regardless of starve_cnt. This is a one-shot core_first flag, cleared after that cycle.
- A single-beat DMA (last=1 in ARB) never enters DMA_LOCK.
- Simultaneous requests in ARB with starve_cnt<STARVE_LIMIT: core wins.
- Reset, including mid-burst:
  - state=ARB; starve_cnt=0; beat_cnt=0; core_first=0.
  - c_rsp_valid=0, d_rsp_valid=0; c_rsp_rdata=0, d_rsp_rdata=0.
  - busy=0.
  - Any pending response is discarded.

Optional Feature:
- Macro DMEM_ARB_STATS_EN. When defined, the block adds three outputs, each 16 bits and saturating at 16'hFFFF, cleared by reset:
  - stat_core_grants: accepted core beats
  - stat_dma_grants: accepted DMA beats
  - stat_conflicts: cycles with both valids high
- When not defined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Core load addr 0x3, memory holds 32'h00000193 -> c_req_ready=1 same cycle; c_rsp_valid=1 next cycle, c_rsp_rdata=32'h00000193; mem_store_instruction=0.
- Core store 0x5 <= 32'hDEADBEEF, then load 0x5 -> mem_store_instruction=1 one cycle; load returns 32'hDEADBEEF.
- Both valid continuously, DMA single-beat loads -> core granted 4 cycles, DMA granted 5th cycle, starve_cnt back to 0; pattern repeats.
- DMA burst of 3 (last on 3rd), core valid throughout -> busy=1 for beats 2-3; c_req_ready=0 until the cycle after the last beat.
- DMA 10-beat burst with no last, MAX_BURST=8, core valid -> release after 8th beat; core granted next cycle; DMA then regains the grant per the ARB rules.
- reset_n low mid-burst with a load response pending -> busy=0, rsp_valid=0 immediately; after release the core is granted first with both valid.
